// File: rtl/mem_responder_if.sv
// CPU-side memory request bundle: level-held read/write request in,
// one-cycle response pulse and registered read data out.
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        busy;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_rdata, mem_resp, busy
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_rdata, mem_resp, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: turns one CPU request into a single access to an
// asynchronous 16-bit SRAM with configurable strobe wait states.
module mem_responder #(
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned WRITE_WAIT = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  mem_responder_if.slave        bus,
  input  logic [15:0]           sram_dq_i,
  output logic [14:0]           sram_addr,
  output logic [15:0]           sram_dq_o,
  output logic                  sram_dq_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_lb_n,
  output logic                  sram_ub_n
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RESP} state_t;

  localparam logic [3:0] RD_W = 4'(READ_WAIT);
  localparam logic [3:0] WR_W = 4'(WRITE_WAIT);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        wr_q;
  logic [1:0]  be_q;
  logic [14:0] addr_q;
  logic [15:0] dq_o_q;
  logic [15:0] rdata_q;
  logic        dq_oe_q;
  logic        ce_n_q, oe_n_q, we_n_q, lb_n_q, ub_n_q;
  logic        resp_q, busy_q;

  // Word-addressed SRAM: the byte-select address bit carries no information.
  logic unused_addr_bit;
  assign unused_addr_bit = bus.mem_address[0];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      dq_o_q  <= '0;
      rdata_q <= '0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.mem_write || bus.mem_read) begin
            state_q <= SETUP;
            wr_q    <= bus.mem_write;
            be_q    <= bus.mem_byte_enable;
            addr_q  <= bus.mem_address[15:1];
            if (bus.mem_write) dq_o_q <= bus.mem_wdata;
            dq_oe_q <= bus.mem_write;
            ce_n_q  <= 1'b0;
            // Reads always fetch the full word; writes gate each lane.
            lb_n_q  <= bus.mem_write ? ~bus.mem_byte_enable[0] : 1'b0;
            ub_n_q  <= bus.mem_write ? ~bus.mem_byte_enable[1] : 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SETUP: begin
          state_q <= STROBE;
          cnt_q   <= wr_q ? WR_W : RD_W;
          oe_n_q  <= wr_q;
          // An all-lanes-off write still runs the sequence but never strobes.
          we_n_q  <= ~(wr_q && (be_q != 2'b00));
        end
        STROBE: begin
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            resp_q  <= 1'b1;
            if (!wr_q) rdata_q <= sram_dq_i;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          resp_q  <= 1'b0;
          busy_q  <= 1'b0;
          ce_n_q  <= 1'b1;
          lb_n_q  <= 1'b1;
          ub_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_resp  = resp_q;
  assign bus.busy      = busy_q;
  assign sram_addr     = addr_q;
  assign sram_dq_o     = dq_o_q;
  assign sram_dq_oe    = dq_oe_q;
  assign sram_ce_n     = ce_n_q;
  assign sram_oe_n     = oe_n_q;
  assign sram_we_n     = we_n_q;
  assign sram_lb_n     = lb_n_q;
  assign sram_ub_n     = ub_n_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: SRAM pin model, cycle-level reference model of
// the access sequence, directed boundary cases and randomized requests.
module tb_mem_responder;
  localparam int RW = 2;
  localparam int WW = 3;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] sram_dq_i;
  logic [14:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

  mem_responder_if bus();

  mem_responder #(.READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus),
    .sram_dq_i(sram_dq_i), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // SRAM pin model and the bench's own expected contents.
  logic [15:0] sram  [0:32767];
  logic [15:0] ref_m [0:32767];

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr] : 16'h5A5A;

  always @(posedge sram_we_n) begin
    if (sram_ce_n === 1'b0) begin
      if (!sram_lb_n) sram[sram_addr][7:0]  <= sram_dq_o[7:0];
      if (!sram_ub_n) sram[sram_addr][15:8] <= sram_dq_o[15:8];
    end
  end

  // Reference model: position within the current access, counted from acceptance.
  bit          m_act;
  int          m_cyc, m_w;
  bit          m_wr;
  logic [1:0]  m_be;
  logic [14:0] m_addr;
  logic [15:0] m_dq, m_wd, m_rdata;

  initial begin
    forever begin
      @(posedge Clk or posedge Reset);
      if (Reset) begin
        m_act = 0; m_addr = '0; m_dq = '0; m_rdata = '0;
      end else if (!m_act) begin
        if (bus.mem_write || bus.mem_read) begin
          m_act = 1; m_cyc = 1; m_wr = bus.mem_write;
          m_addr = bus.mem_address[15:1]; m_be = bus.mem_byte_enable;
          m_wd = bus.mem_wdata; m_w = m_wr ? WW : RW;
          if (m_wr) m_dq = bus.mem_wdata;
        end
      end else begin
        m_cyc++;
        if (m_cyc == m_w + 2) begin
          if (m_wr) begin
            if (m_be[0]) ref_m[m_addr][7:0]  = m_wd[7:0];
            if (m_be[1]) ref_m[m_addr][15:8] = m_wd[15:8];
          end else begin
            m_rdata = ref_m[m_addr];
          end
        end
        if (m_cyc == m_w + 3) m_act = 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        bit strobe;
        strobe = m_act && m_cyc >= 2 && m_cyc <= m_w + 1;
        chk("busy",     bus.busy,     m_act);
        chk("mem_resp", bus.mem_resp, m_act && m_cyc == m_w + 2);
        chk("mem_rdata", bus.mem_rdata, m_rdata);
        chk("ce_n",  sram_ce_n, !m_act);
        chk("oe_n",  sram_oe_n, !(strobe && !m_wr));
        chk("we_n",  sram_we_n, !(strobe && m_wr && m_be != 2'b00));
        chk("lb_n",  sram_lb_n, m_act ? (m_wr ? !m_be[0] : 1'b0) : 1'b1);
        chk("ub_n",  sram_ub_n, m_act ? (m_wr ? !m_be[1] : 1'b0) : 1'b1);
        chk("dq_oe", sram_dq_oe, m_act && m_wr);
        chk("addr",  sram_addr, m_addr);
        chk("dq_o",  sram_dq_o, m_dq);
        if (m_act && m_wr && m_cyc == m_w + 2)
          chk("sram_contents", sram[m_addr], ref_m[m_addr]);
      end
    end
  end

  int oe_low, we_low, resp_cnt;
  initial begin
    forever begin
      @(negedge Clk);
      if (!sram_oe_n) oe_low++;
      if (!sram_we_n) we_low++;
      if (bus.mem_resp) resp_cnt++;
    end
  end

  task automatic wait_resp(output int lat);
    lat = 0;
    forever begin
      @(negedge Clk);
      lat++;
      if (bus.mem_resp) break;
      if (lat > 40) begin
        errors++; checks++;
        $display("FAIL resp_timeout: got no mem_resp within %0d cycles", lat);
        break;
      end
    end
  endtask

  task automatic access(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] d, input logic [1:0] be,
                        input bit hold, output int lat);
    int lat2;
    @(negedge Clk);
    bus.mem_read = rd; bus.mem_write = wr;
    bus.mem_address = a; bus.mem_wdata = d; bus.mem_byte_enable = be;
    oe_low = 0; we_low = 0; resp_cnt = 0;
    wait_resp(lat);
    if (hold) begin
      @(negedge Clk);
      @(negedge Clk);
    end
    bus.mem_read = 0; bus.mem_write = 0;
    if (hold) wait_resp(lat2);
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 32768; i++) begin
      sram[i]  = 16'(i * 40503) ^ 16'h3C3C;
      ref_m[i] = sram[i];
    end
    sram[15'h081] = 16'hBEEF; ref_m[15'h081] = 16'hBEEF;
    sram[15'h008] = 16'hABCD; ref_m[15'h008] = 16'hABCD;
    sram[15'h020] = 16'h1111; ref_m[15'h020] = 16'h1111;
    bus.mem_read = 0; bus.mem_write = 0;
    bus.mem_address = '0; bus.mem_wdata = '0; bus.mem_byte_enable = '0;

    repeat (3) @(negedge Clk);
    chk("rst_ce_n", sram_ce_n, 1'b1);
    chk("rst_oe_n", sram_oe_n, 1'b1);
    chk("rst_we_n", sram_we_n, 1'b1);
    chk("rst_lanes", {sram_lb_n, sram_ub_n}, 2'b11);
    chk("rst_dq_oe", sram_dq_oe, 1'b0);
    chk("rst_resp", bus.mem_resp, 1'b0);
    chk("rst_rdata", bus.mem_rdata, 16'h0000);
    #1 Reset = 1'b0;

    // Read, default wait states
    access(1, 0, 16'h0102, 16'h0, 2'b00, 0, lat);
    chk("rd_latency", lat, 4);
    chk("rd_oe_cycles", oe_low, 2);
    chk("rd_resp_pulses", resp_cnt, 1);
    chk("rd_data", bus.mem_rdata, 16'hBEEF);
    chk("rd_addr", sram_addr, 15'h081);

    // Low-byte write with three wait states
    access(0, 1, 16'h0010, 16'h1234, 2'b01, 0, lat);
    chk("wr_latency", lat, 5);
    chk("wr_we_cycles", we_low, 3);
    chk("wr_low_byte", sram[15'h008], 16'hAB34);

    // No-lane write
    access(0, 1, 16'h0010, 16'hFFFF, 2'b00, 0, lat);
    chk("wr0_latency", lat, 5);
    chk("wr0_we_cycles", we_low, 0);
    chk("wr0_unchanged", sram[15'h008], 16'hAB34);

    // Read+write together, held one extra cycle past the response
    access(1, 1, 16'h0040, 16'hC0DE, 2'b11, 1, lat);
    chk("both_resp_pulses", resp_cnt, 2);
    chk("both_wrote", sram[15'h020], 16'hC0DE);
    chk("both_no_oe", oe_low, 0);

    // Reset in the middle of a read strobe
    @(negedge Clk);
    bus.mem_read = 1; bus.mem_address = 16'h0102;
    @(negedge Clk);
    @(negedge Clk);
    chk("pre_rst_oe_n", sram_oe_n, 1'b0);
    #1 Reset = 1'b1; bus.mem_read = 0;
    #1;
    chk("arst_oe_n", sram_oe_n, 1'b1);
    chk("arst_ce_n", sram_ce_n, 1'b1);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_resp", bus.mem_resp, 1'b0);
    chk("arst_rdata", bus.mem_rdata, 16'h0000);
    @(negedge Clk);
    #1 Reset = 1'b0;
    access(1, 0, 16'h0102, 16'h0, 2'b00, 0, lat);
    chk("post_rst_latency", lat, 4);
    chk("post_rst_data", bus.mem_rdata, 16'hBEEF);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      bit rd, wr, hold;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1;
      hold = ($urandom_range(0, 7) == 0);
      access(rd, wr, 16'($urandom_range(0, 127)), 16'($urandom),
             2'($urandom_range(0, 3)), hold, lat);
      chk("rand_latency", lat, wr ? WW + 2 : RW + 2);
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    repeat (4) @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's memory request interface: accepts a level-held `mem_read`/`mem_write` request with address, write data and byte enables, performs one access to an external asynchronous 16-bit SRAM with configurable wait states, and returns a one-cycle `mem_resp` together with registered read data. It sits between the CPU control/datapath (MAR/MDR side) and the board SRAM pins.

## Interface
- `READ_WAIT`, 2: cycles `sram_oe_n` is held low per read; legal range 1..15.
- `WRITE_WAIT`, 2: cycles `sram_we_n` is held low per write; legal range 1..15.
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `mem_read`  in  1  read request; held high until `mem_resp`.
- `mem_write`  in  1  write request; held high until `mem_resp`.
- `mem_address`  in  16  byte address; bit 0 ignored (word access).
- `mem_wdata`  in  16  write data; [7:0] low byte, [15:8] high byte.
- `mem_byte_enable`  in  2  bit0 = low byte, bit1 = high byte (writes only).
- `mem_rdata`  out  16  registered read data; holds until the next read completes.
- `mem_resp`  out  1  one-cycle completion pulse.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `sram_addr`  out  15  word address = latched `mem_address[15:1]`.
- `sram_dq_i`  in  16  SRAM data bus input.
- `sram_dq_o`  out  16  SRAM data bus output.
- `sram_dq_oe`  out  1  tristate enable for `sram_dq_o`.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_lb_n`, `sram_ub_n`  out  1 each  active-low SRAM strobes.

## Operation
- FSM states: IDLE, SETUP, STROBE, RESP.
- IDLE: if `mem_write` or `mem_read` is high at a rising edge, latch address, wdata, byte enables and op into internal registers and go to SETUP. A write takes priority when both are high. Request inputs are ignored in every other state; changes mid-access have no effect.
- SETUP (1 cycle):
  - `sram_ce_n`=0 and `sram_addr` driven; `sram_oe_n`=`sram_we_n`=1.
  - Write: `sram_dq_o`=latched wdata, `sram_dq_oe`=1.
  - Lane strobes: read drives `lb_n`=`ub_n`=0 (byte enables ignored); write drives `lb_n`=~be[0], `ub_n`=~be[1].
  - Load the wait counter with READ_WAIT or WRITE_WAIT according to op.
- STROBE: strobe outputs as in SETUP, plus `sram_oe_n`=0 (read) or `sram_we_n`=0 (write). Counter decrements each cycle and the FSM moves to RESP after the cycle in which it reads 1. Read: `mem_rdata` <= `sram_dq_i` at the edge ending the last STROBE cycle.
- Write with `mem_byte_enable`=00: the sequence runs normally but `sram_we_n` stays 1 throughout; `mem_resp` still pulses (no-op write).
- RESP (1 cycle):
  - `mem_resp`=1, `sram_oe_n`=`sram_we_n`=1.
  - `sram_ce_n`, `sram_addr`, lane strobes, `sram_dq_o` and `sram_dq_oe` keep their SETUP values (address/data hold).
  - Then IDLE.
- IDLE outputs: all `_n` strobes 1, `sram_dq_oe`=0. `sram_addr` and `sram_dq_o` keep their last values.
- The requester deasserts its request in the cycle after `mem_resp`. A request still high in IDLE is treated as a new request.
- Reset (async, any state, including mid-access):
  - FSM goes to IDLE.
  - `mem_resp`=0, `busy`=0, `mem_rdata`=0, `sram_addr`=0, `sram_dq_o`=0, `sram_dq_oe`=0.
  - All `_n` strobes go to 1 immediately; the in-flight access is abandoned with no response.

## Timing
- Acceptance edge E0 (IDLE with a request) is followed by: SETUP in cycle 1, STROBE in cycles 2..W+1, RESP in cycle W+2, IDLE in cycle W+3. W is READ_WAIT or WRITE_WAIT.
- Request-to-response latency is W+2 cycles. Minimum back-to-back period is W+3 cycles.
- Defaults give `mem_resp` in cycle 4 after acceptance.
- `mem_rdata` is valid in the RESP cycle and stays stable until the end of the next read's last STROBE cycle.
- All outputs are registered or decoded from registered state only; no combinational path from request inputs to outputs.

## Test plan
- Reset then idle: all `_n` strobes = 1, `sram_dq_oe`=0, `mem_resp`=0, `mem_rdata`=0000.
- Read at 0x0102 with SRAM model returning 0xBEEF, defaults: `sram_addr`=0x081, `sram_oe_n` low exactly 2 cycles, `mem_resp` high in cycle 4 for 1 cycle, `mem_rdata`=0xBEEF.
- Write 0x1234 to 0x0010 with be=01, WRITE_WAIT=3: `sram_we_n` low 3 cycles, `lb_n`=0, `ub_n`=1, `dq_oe` high cycles 1..5, and the model updates only the low byte to 0x34.
- Write with be=00: `sram_we_n` never falls, `mem_resp` pulses in cycle 4, SRAM contents unchanged.
- Simultaneous `mem_read`+`mem_write`, then request held through `mem_resp` for one extra cycle: a write is performed, and a second access is accepted from IDLE.
- Assert `Reset` during STROBE of a read: strobes return high asynchronously, no `mem_resp`, `busy`=0; a subsequent read completes normally.
